// File: rtl/trace_capture.sv
// Bus-trace buffer: captures CPU memory writes (and, with TRACE_FETCH_EN defined,
// instruction fetches) into a FWFT FIFO drained by a valid/ready host port.
module trace_capture #(
  parameter int          DEPTH       = 16,
  parameter logic [5:0]  FETCH_STATE = 6'd0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic [5:0]                 estado,
  input  logic [31:0]                pc,
  input  logic [31:0]                mem_addr,
  input  logic                       mem_wr,
  input  logic [31:0]                wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [64:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Host handshake: an entry leaves the FIFO on an edge where out_valid and
  // out_ready are both high; out_data holds until that edge.
  logic [64:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_drop;

  logic        w_wr_evt;
  logic        w_fetch_evt;
  logic        w_evt;
  logic        w_pop;
  logic        w_full;
  logic        w_push;
  logic        w_collide;
  logic [64:0] w_entry;
  logic [1:0]  w_drops;
  logic [16:0] w_drop_sum;

  assign w_wr_evt = trace_en & mem_wr;

`ifdef TRACE_FETCH_EN
  logic [5:0] r_estado_prev;

  // Reset value differs from any legal FETCH_STATE so the first fetch is seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado_prev <= 6'h3F;
    else        r_estado_prev <= estado;
  end

  assign w_fetch_evt = trace_en & (estado == FETCH_STATE) & (r_estado_prev != FETCH_STATE);
  assign w_entry     = w_wr_evt ? {1'b1, mem_addr, wdata} : {1'b0, pc, 32'h0};
`else
  logic w_unused;
  assign w_unused    = ^{estado, pc};
  assign w_fetch_evt = 1'b0;
  assign w_entry     = {1'b1, mem_addr, wdata};
`endif

  assign w_evt     = w_wr_evt | w_fetch_evt;
  assign w_collide = w_wr_evt & w_fetch_evt;
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push    = w_evt & (~w_full | w_pop);

  // A full FIFO plus a write/fetch collision loses two events in one cycle.
  assign w_drops    = {1'b0, w_collide} + {1'b0, w_evt & ~w_push};
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_drops);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (~w_push & w_pop) r_count <= r_count - CW'(1);
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign count      = r_count;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (DEPTH = 16); fetch checks
// follow the TRACE_FETCH_EN build option.
module tb_trace_capture;

  localparam int DEPTH = 16;

  logic        clock;
  logic        reset;
  logic        trace_en;
  logic [5:0]  estado;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] out_data;
  logic [4:0]  count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_drop = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp_head;

  trace_capture #(.DEPTH(DEPTH), .FETCH_STATE(6'd0)) dut (
    .clock      (clock),
    .reset      (reset),
    .trace_en   (trace_en),
    .estado     (estado),
    .pc         (pc),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .wdata      (wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .drop_count (drop_count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one write event; the scoreboard gets the entry if it is expected to fit.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input bit expect_push);
    trace_en = 1'b1;
    mem_wr   = 1'b1;
    mem_addr = a;
    wdata    = d;
    if (expect_push) exp_q.push_back({1'b1, a, d});
  endtask

  task automatic drain_and_check(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_head = exp_q.pop_front();
      check("drain_valid", 65'(out_valid), 65'd1);
      check("drain_data", out_data, exp_head);
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; trace_en = 1'b0; estado = 6'h3; pc = '0;
    mem_addr = '0; mem_wr = 1'b0; wdata = '0; out_ready = 1'b0;
    #3;
    check("rst_valid", 65'(out_valid), 65'd0);
    check("rst_count", 65'(count), 65'd0);
    check("rst_drop", 65'(drop_count), 65'd0);
    check("rst_data", out_data, 65'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Fetch on estado 3 -> 0
    trace_en = 1'b1; estado = 6'h3;
    tick();
    estado = 6'h0; pc = 32'h0000_0040;
    tick();
`ifdef TRACE_FETCH_EN
    check("fetch_valid", 65'(out_valid), 65'd1);
    check("fetch_data", out_data, {1'b0, 32'h40, 32'h0});
    check("fetch_count", 65'(count), 65'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`else
    check("nofetch_count", 65'(count), 65'd0);
`endif
    check("fetch_drained", 65'(count), 65'd0);

    // Write colliding with a fetch edge
    estado = 6'h3;
    tick();
    estado = 6'h0;
    drive_write(32'h100, 32'hDEAD_BEEF, 1'b0);
    tick();
    mem_wr = 1'b0;
`ifdef TRACE_FETCH_EN
    exp_drop = 1;
`endif
    check("collide_count", 65'(count), 65'd1);
    check("collide_data", out_data, {1'b1, 32'h100, 32'hDEAD_BEEF});
    check("collide_drop", 65'(drop_count), 65'(exp_drop));
    tick();
    check("collide_hold", 65'(count), 65'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("collide_pop", 65'(count), 65'd0);
    estado = 6'h3;

    // 18 writes into a 16-entry FIFO with no reads
    for (int i = 0; i < 18; i++) begin
      drive_write(32'h200 + 32'(i), 32'hA000_0000 + 32'(i), i < DEPTH);
      tick();
    end
    mem_wr = 1'b0;
    exp_drop += 2;
    check("full_count", 65'(count), 65'd16);
    check("full_drop", 65'(drop_count), 65'(exp_drop));
    drain_and_check(DEPTH);
    check("empty_valid", 65'(out_valid), 65'd0);
    check("empty_count", 65'(count), 65'd0);

    // Full FIFO with concurrent push and pop across pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive_write(32'h300 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive_write(32'h400 + 32'(i), 32'hC000_0000 + 32'(i), 1'b1);
      exp_head = exp_q.pop_front();
      check("stream_data", out_data, exp_head);
      tick();
      check("stream_count", 65'(count), 65'd16);
    end
    mem_wr = 1'b0;
    out_ready = 1'b0;
    check("stream_drop", 65'(drop_count), 65'(exp_drop));
    drain_and_check(DEPTH);
    check("stream_empty", 65'(out_valid), 65'd0);

    // estado held at FETCH_STATE for five cycles
    estado = 6'h3;
    tick();
    estado = 6'h0; pc = 32'h0000_0080;
    for (int i = 0; i < 5; i++) tick();
    estado = 6'h3;
`ifdef TRACE_FETCH_EN
    check("hold_count", 65'(count), 65'd1);
    check("hold_data", out_data, {1'b0, 32'h80, 32'h0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`else
    check("hold_count", 65'(count), 65'd0);
`endif
    check("hold_drained", 65'(count), 65'd0);

    // Writes with trace_en low
    for (int i = 0; i < 4; i++) begin
      drive_write(32'h500 + 32'(i), 32'h5555_0000 + 32'(i), 1'b0);
      trace_en = 1'b0;
      tick();
    end
    mem_wr = 1'b0; trace_en = 1'b1;
    check("dis_count", 65'(count), 65'd0);
    check("dis_drop", 65'(drop_count), 65'(exp_drop));

    // Reach count 7 with a nonzero drop_count, then reset mid-cycle
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_write(32'h600 + 32'(i), 32'h6666_0000 + 32'(i), 1'b0);
      tick();
    end
    mem_wr = 1'b0;
    exp_drop += 1;
    check("pre_drop", 65'(drop_count), 65'(exp_drop));
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    out_ready = 1'b0;
    check("pre_count", 65'(count), 65'd7);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 65'(count), 65'd0);
    check("async_valid", 65'(out_valid), 65'd0);
    check("async_drop", 65'(drop_count), 65'd0);
    check("async_data", out_data, 65'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("post_count", 65'(count), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
